// File: rtl/line_buffer_stream.sv
// line_buffer_stream: KER_SIZE-bank streaming line buffer presenting KER_SIZE-1 stored rows plus the live pixel.
// Define LINE_BUFFER_ZERO_PAD_EN for top-edge zero padding (beats valid from row 0, unprimed rows forced to 0).
module line_buffer_stream #(
    parameter int KER_SIZE = 3,
    parameter int DW       = 32,
    parameter int IMG_W    = 32,
    parameter int AW       = $clog2(IMG_W)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [DW-1:0]                in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_pix,
    output logic [(KER_SIZE-1)*DW-1:0]   out_rows,
    output logic [AW-1:0]                out_col,
    output logic                         out_eol
);
    localparam int BW = $clog2(KER_SIZE);
    localparam int NS = KER_SIZE - 1;
`ifdef LINE_BUFFER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic [AW-1:0] col_q, col_d, cur_col, out_col_q, out_col_d;
    logic [BW-1:0] wr_bank_q, wr_bank_d, cur_bank, wr_bank_d1_q, wr_bank_d1_d;
    logic [BW-1:0] rows_done_q, rows_done_d, cur_rows, rows_done_d1_q, rows_done_d1_d;
    logic [DW-1:0] out_pix_q, out_pix_d;
    logic          out_valid_q, out_valid_d, out_eol_q, out_eol_d, accept, last;
    logic [KER_SIZE-1:0][DW-1:0] q_all;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_col   = out_col_q;
    assign out_eol   = out_eol_q;

    always_comb begin
        cur_col        = in_sof ? '0 : col_q;
        cur_bank       = in_sof ? '0 : wr_bank_q;
        cur_rows       = in_sof ? '0 : rows_done_q;
        last           = cur_col == AW'(IMG_W - 1);
        col_d          = col_q;
        wr_bank_d      = wr_bank_q;
        rows_done_d    = rows_done_q;
        wr_bank_d1_d   = wr_bank_d1_q;
        rows_done_d1_d = rows_done_d1_q;
        out_pix_d      = out_pix_q;
        out_col_d      = out_col_q;
        out_eol_d      = out_eol_q;
        out_valid_d    = out_ready ? 1'b0 : out_valid_q;
        if (accept) begin
            col_d          = last ? '0 : cur_col + AW'(1);
            wr_bank_d      = !last ? cur_bank : (cur_bank == BW'(NS)) ? '0 : cur_bank + BW'(1);
            rows_done_d    = (last && cur_rows != BW'(NS)) ? cur_rows + BW'(1) : cur_rows;
            wr_bank_d1_d   = cur_bank;
            rows_done_d1_d = cur_rows;
            out_pix_d      = in_data;
            out_col_d      = cur_col;
            out_eol_d      = last;
            out_valid_d    = PAD_EN || cur_rows == BW'(NS);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q          <= '0;
            wr_bank_q      <= '0;
            rows_done_q    <= '0;
            wr_bank_d1_q   <= '0;
            rows_done_d1_q <= '0;
            out_pix_q      <= '0;
            out_col_q      <= '0;
            out_eol_q      <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            col_q          <= col_d;
            wr_bank_q      <= wr_bank_d;
            rows_done_q    <= rows_done_d;
            wr_bank_d1_q   <= wr_bank_d1_d;
            rows_done_d1_q <= rows_done_d1_d;
            out_pix_q      <= out_pix_d;
            out_col_q      <= out_col_d;
            out_eol_q      <= out_eol_d;
            out_valid_q    <= out_valid_d;
        end
    end

    // One single-port bank per row; the bank being written is never selected for output.
    for (genvar b = 0; b < KER_SIZE; b++) begin : g_bank
        logic [DW-1:0] mem [IMG_W];
        logic [DW-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (accept && cur_bank == BW'(b)) mem[cur_col] <= in_data;
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) rd_q <= '0;
            else if (accept && cur_bank != BW'(b)) rd_q <= mem[cur_col];
        end
        assign q_all[b] = rd_q;
    end

    always_comb begin
        int idx;
        idx      = 0;
        out_rows = '0;
        for (int j = 0; j < NS; j++) begin
            idx = (int'(wr_bank_d1_q) + 1 + j) % KER_SIZE;
            out_rows[j*DW +: DW] = (!PAD_EN || int'(rows_done_d1_q) >= NS - j) ? q_all[idx[BW-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_line_buffer_stream.sv
// tb_line_buffer_stream: drives line_buffer_stream (K=3, DW=8, IMG_W=4) against a frame-image reference model.
// Honours LINE_BUFFER_ZERO_PAD_EN the same way as the design.
module tb_line_buffer_stream;
    localparam int K = 3, DW = 8, W = 4, AW = 2;

    logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid, out_eol;
    logic [DW-1:0] out_pix;
    logic [(K-1)*DW-1:0] out_rows;
    logic [AW-1:0] out_col;

    line_buffer_stream #(.KER_SIZE(K), .DW(DW), .IMG_W(W), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_rows(out_rows), .out_col(out_col), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    int n = 0, err = 0;
    bit m_valid, m_eol, exp_ready, obs_ready;
    logic [7:0] m_pix;
    logic [1:0] m_col;
    logic [15:0] m_rows;
    int m_row, m_c;
    logic [7:0] img [64][W];

    task automatic model_reset;
        m_valid = 0; m_eol = 0; m_pix = '0; m_col = '0; m_rows = '0; m_row = 0; m_c = 0;
    endtask

    // Model: frame-relative row/column of every accepted pixel; a beat shows rows r-2, r-1 at its column.
    task automatic step(input bit v, input bit s, input logic [7:0] d, input bit r);
        int rr;
        in_valid = v; in_sof = s; in_data = d; out_ready = r;
        #1;
        obs_ready = in_ready;
        exp_ready = !m_valid || r;
        @(posedge clk);
        if (v && exp_ready) begin
            if (s) begin m_row = 0; m_c = 0; end
            img[m_row % 64][m_c] = d;
            m_pix = d; m_col = m_c[1:0]; m_eol = (m_c == W - 1);
            for (int j = 0; j < K - 1; j++) begin
                rr = m_row - (K - 1) + j;
                m_rows[j*8 +: 8] = (rr < 0) ? 8'h00 : img[rr % 64][m_c];
            end
`ifdef LINE_BUFFER_ZERO_PAD_EN
            m_valid = 1;
`else
            m_valid = (m_row >= K - 1);
`endif
            if (m_c == W - 1) begin m_c = 0; m_row++; end else m_c++;
        end else if (r) m_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n++; if ({out_pix, out_col, out_eol} !== 11'h0) begin err++; $display("FAIL reset_out_regs got=%h/%h/%b want=0", out_pix, out_col, out_eol); end
        n++; if (out_rows !== 16'h0) begin err++; $display("FAIL reset_out_rows got=%h want=0000", out_rows); end
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_stream;
        for (int r = 0; r < 4; r++) for (int c = 0; c < W; c++) begin
            step(1, r == 0 && c == 0, 8'(r * 16 + c), 1);
            n++; if (obs_ready !== exp_ready || out_valid !== m_valid) begin err++;
                $display("FAIL stream_hs r%0d c%0d ready=%b want=%b valid=%b want=%b", r, c, obs_ready, exp_ready, out_valid, m_valid); end
            if (m_valid) begin n++; if ({out_pix, out_col, out_eol, out_rows} !== {m_pix, m_col, m_eol, m_rows}) begin err++;
                $display("FAIL stream_beat r%0d c%0d got=%h/%0d/%b/%h want=%h/%0d/%b/%h", r, c, out_pix, out_col, out_eol, out_rows, m_pix, m_col, m_eol, m_rows); end end
`ifdef LINE_BUFFER_ZERO_PAD_EN
            if (r == 0 && c == 1) begin n++; if ({out_valid, out_rows} !== {1'b1, 16'h0000}) begin err++;
                $display("FAIL pad_row0 got=%b/%h want=1/0000", out_valid, out_rows); end end
            if (r == 1 && c == 2) begin n++; if (out_rows !== 16'h0200) begin err++;
                $display("FAIL pad_row1 got=%h want=0200", out_rows); end end
`else
            if (r < 2) begin n++; if (out_valid !== 1'b0) begin err++; $display("FAIL unprimed_valid r%0d c%0d got=%b want=0", r, c, out_valid); end end
            if (r == 2 && c == 0) begin n++; if ({out_valid, out_pix, out_rows} !== {1'b1, 8'h20, 16'h1000}) begin err++;
                $display("FAIL first_beat got=%b/%h/%h want=1/20/1000", out_valid, out_pix, out_rows); end end
            if (r == 3 && c == 3) begin n++; if ({out_valid, out_pix, out_rows, out_eol} !== {1'b1, 8'h33, 16'h2313, 1'b1}) begin err++;
                $display("FAIL last_beat got=%b/%h/%h/%b want=1/33/2313/1", out_valid, out_pix, out_rows, out_eol); end end
`endif
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] held;
        step(1, 0, 8'h40, 1);
        step(1, 0, 8'h41, 1);
        held = out_pix;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'h42, 0);
            n++; if (obs_ready !== 1'b0 || out_pix !== held || out_col !== 2'd1 || out_valid !== 1'b1) begin err++;
                $display("FAIL stall_%0d ready=%b pix=%h col=%0d valid=%b want=0/%h/1/1", i, obs_ready, out_pix, out_col, out_valid, held); end
        end
        step(1, 0, 8'h42, 1);
        n++; if ({out_valid, out_pix, out_col} !== {1'b1, 8'h42, 2'd2}) begin err++;
            $display("FAIL resume got=%b/%h/%0d want=1/42/2", out_valid, out_pix, out_col); end
        step(1, 0, 8'h43, 1);
        n++; if ({out_pix, out_col, out_eol, out_rows} !== {m_pix, m_col, m_eol, m_rows} || out_col !== 2'd3) begin err++;
            $display("FAIL resume_next got=%h/%0d/%b/%h want=%h/3/%b/%h", out_pix, out_col, out_eol, out_rows, m_pix, m_eol, m_rows); end
    endtask

    task automatic test_sof;
        for (int k = 0; k < 2 * W + 2; k++) step(1, k == 0, 8'(8'h80 + k), 1);
        step(1, 1, 8'h22, 1);
        n++; if (out_col !== 2'd0 || out_valid !== m_valid) begin err++;
            $display("FAIL sof_col got=%0d/%b want=0/%b", out_col, out_valid, m_valid); end
        for (int k = 1; k <= 2 * W; k++) begin
            step(1, 0, 8'(8'h90 + k), 1);
`ifdef LINE_BUFFER_ZERO_PAD_EN
            n++; if (out_valid !== 1'b1 || out_rows !== m_rows) begin err++;
                $display("FAIL sof_pad k%0d got=%b/%h want=1/%h", k, out_valid, out_rows, m_rows); end
`else
            n++; if (out_valid !== (k == 2 * W)) begin err++;
                $display("FAIL sof_valid k%0d got=%b want=%b", k, out_valid, k == 2 * W); end
`endif
        end
        n++; if ({out_pix, out_col, out_rows} !== {m_pix, m_col, m_rows}) begin err++;
            $display("FAIL sof_beat got=%h/%0d/%h want=%h/%0d/%h", out_pix, out_col, out_rows, m_pix, m_col, m_rows); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
            n++; if (obs_ready !== exp_ready || out_valid !== m_valid) begin err++;
                $display("FAIL rand_hs i%0d ready=%b want=%b valid=%b want=%b", i, obs_ready, exp_ready, out_valid, m_valid); end
            if (m_valid) begin n++; if ({out_pix, out_col, out_eol, out_rows} !== {m_pix, m_col, m_eol, m_rows}) begin err++;
                $display("FAIL rand_beat i%0d got=%h/%0d/%b/%h want=%h/%0d/%b/%h", i, out_pix, out_col, out_eol, out_rows, m_pix, m_col, m_eol, m_rows); end end
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 3 * W + 2; k++) step(1, k == 0, 8'(8'hA0 + k), 1);
        rstn = 1'b0;
        #1;
        n++; if ({out_valid, out_rows, in_ready} !== {1'b0, 16'h0, 1'b1}) begin err++;
            $display("FAIL mid_reset got=%b/%h/%b want=0/0000/1", out_valid, out_rows, in_ready); end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3 * W; k++) begin
            step(1, 0, 8'(8'hC0 + k), 1);
            n++; if (out_valid !== m_valid) begin err++; $display("FAIL post_reset_valid k%0d got=%b want=%b", k, out_valid, m_valid); end
            if (m_valid) begin n++; if ({out_pix, out_col, out_rows} !== {m_pix, m_col, m_rows}) begin err++;
                $display("FAIL post_reset_beat k%0d got=%h/%0d/%h want=%h/%0d/%h", k, out_pix, out_col, out_rows, m_pix, m_col, m_rows); end end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_sof();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n, err);
        $finish;
    end
endmodule

// File: doc/line_buffer_stream.md
# line_buffer_stream

Parametrised streaming line buffer for KER_SIZE×KER_SIZE convolution windows. It generalises the fixed k2/k3/k5/k7 SRAM row arrays to any KER_SIZE ≥ 2. It adds internal column/bank pointer control, a valid/ready handshake with backpressure, and frame-start handling. It sits between the pixel input stream and the window/shift-register stage, presenting KER_SIZE-1 stored rows plus the live pixel each beat.

## Interface
- KER_SIZE, 3, kernel height; number of row banks (≥ 2)
- DW, 32, pixel width in bits
- IMG_W, 32, pixels per row; SRAM depth per bank
- AW, $clog2(IMG_W), column address width
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, asynchronous, active-low
- in_valid  input  1  input pixel valid
- in_ready  output  1  block accepts pixel this cycle
- in_sof  input  1  first pixel of frame, qualified by in_valid
- in_data  input  DW  input pixel
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_pix  output  DW  live pixel, delayed to align with rows
- out_rows  output  (KER_SIZE-1)*DW  stored column; slice j = row r-(KER_SIZE-1)+j (slice 0 oldest, slice KER_SIZE-2 = row r-1)
- out_col  output  AW  column index of the beat
- out_eol  output  1  beat is last column of row

## Operation
- KER_SIZE single-port banks of IMG_W×DW, 1-cycle read latency; q holds when the bank is not enabled.
- Accept = in_valid && in_ready. On accept at column c:
  - write in_data into bank wr_bank at address c;
  - read all other banks at address c.
- Registers:
  - col (0..IMG_W-1);
  - wr_bank (0..KER_SIZE-1);
  - rows_done (saturating at KER_SIZE-1).
- On accept with col == IMG_W-1:
  - col → 0;
  - wr_bank → (wr_bank+1) mod KER_SIZE;
  - rows_done increments, saturating.
- Otherwise, on accept, col increments.
- in_sof on an accepted pixel forces that pixel to col 0, wr_bank 0, rows_done 0, regardless of current col; the counters then advance from there. A mid-row sof discards the partial row.
- Row reorder: slice j = q of bank (wr_bank_d1 + 1 + j) mod KER_SIZE, where wr_bank_d1 is wr_bank registered on accept. Implemented as a KER_SIZE-way rotate mux; no hard-coded per-KER_SIZE case tables.
- Slice j is "primed" when rows_done_d1 ≥ KER_SIZE-1-j.
- Output stage is a single register stage:
  - out_pix, out_col, out_eol, wr_bank_d1, rows_done_d1 load on accept;
  - out_rows are combinational from bank q and the registered selects, so they are stable while stalled.
- in_ready = !out_valid || out_ready.
- When stalled, no bank is enabled, so q and all output registers hold.

## Timing
- Reset values: in_ready 1; out_valid 0; out_pix 0; out_rows 0; out_col 0; out_eol 0. Internal col, wr_bank, rows_done and all _d1 registers are 0.
- SRAM contents are not cleared; unprimed slices are masked.
- Latency: pixel accepted at edge N appears on out_* after edge N, with its rows.
- Throughput: 1 pixel/cycle while out_ready is high.
- out_valid sets on accept (subject to Configuration). It clears on out_ready && !accept. It holds while out_ready is low.
- Simultaneous accept and out_ready: the new beat replaces the old one in the same edge; no bubble.
- Wrap: wr_bank KER_SIZE-1 → 0 on the last column.
- Reset mid-frame: all state returns to reset values immediately (async). The first beat after reset behaves as an unprimed frame.

## Configuration
- LINE_BUFFER_ZERO_PAD_EN defined:
  - out_valid asserts from the first row of the frame;
  - unprimed slices of out_rows are driven to 0 (top-edge zero padding).
- LINE_BUFFER_ZERO_PAD_EN undefined:
  - beats with rows_done_d1 < KER_SIZE-1 do not set out_valid (silently consumed; in_ready unaffected);
  - out_rows is unmasked;
  - the first valid beat is row KER_SIZE-1, col 0.

## Test plan
- KER_SIZE=3, DW=8, IMG_W=4, pad off; stream pixels = row*16+col for rows 0–3 with out_ready=1 → first out_valid at row 2 col 0, with out_pix 0x20, out_rows slice0 0x00, slice1 0x10. Row 3 col 3 → out_pix 0x33, slices 0x13, 0x23, out_eol 1.
- Same stream with pad on → row 0 col 1 gives out_valid 1, out_rows 0x0000. Row 1 col 2 gives slice1 0x02, slice0 0x00.
- KER_SIZE=5, 8 rows → bank wrap verified: row 6 col 0 slices = 0x20, 0x30, 0x40, 0x50.
- Backpressure: out_ready low for 3 cycles mid-row → in_ready low, out_* stable. Resume with no lost or duplicated column.
- in_sof asserted at row 2 col 2 → that pixel reported as col 0. With pad off, out_valid stays low until 2 full rows after the sof.
- rstn pulse mid-row 3 → out_valid 0, out_rows 0 during reset. The next frame restarts unprimed, with no stale rows visible when pad is on.
